// File: rtl/pgm_loader_pkg.sv
// Shared definitions for the program loader: frame state encoding and the
// default bus widths / frame start byte used by the SoC ROM write port.
package pgm_loader_pkg;

  localparam int         ADDR_BUS_WIDTH_DEF = 16;
  localparam int         ROM_ADDR_WIDTH_DEF = 15;
  localparam logic [7:0] MAGIC_DEF          = 8'hA5;

  // Frame fields arrive in this order; the encoding follows the byte order.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR_L = 3'd1;
  localparam logic [2:0] S_ADDR_H = 3'd2;
  localparam logic [2:0] S_LEN_L  = 3'd3;
  localparam logic [2:0] S_LEN_H  = 3'd4;
  localparam logic [2:0] S_DATA   = 3'd5;
  localparam logic [2:0] S_CSUM   = 3'd6;
  localparam logic [2:0] S_REPORT = 3'd7;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/pgm_loader_if.sv
// Host byte stream plus ROM write port and status of the program loader.
interface pgm_loader_if #(
  parameter int ADDR_BUS_WIDTH = pgm_loader_pkg::ADDR_BUS_WIDTH_DEF
);
  logic [7:0]                in_data_i;
  logic                      in_valid_i;
  logic                      in_ready_o;
  logic [ADDR_BUS_WIDTH-1:0] pgm_addr_write_o;
  logic [7:0]                pgm_data_write_o;
  logic                      pgm_write_o;
  logic                      core_rst_o;
  logic                      busy_o;
  logic                      done_o;
  logic                      err_o;

  modport slave (
    input  in_data_i, in_valid_i,
    output in_ready_o, pgm_addr_write_o, pgm_data_write_o, pgm_write_o,
           core_rst_o, busy_o, done_o, err_o
  );

  modport master (
    output in_data_i, in_valid_i,
    input  in_ready_o, pgm_addr_write_o, pgm_data_write_o, pgm_write_o,
           core_rst_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/pgm_loader_frame_fsm.sv
// Frame parser: header fields, payload index, running checksum and the
// busy/done/err/core-reset flags. Emits an unregistered write request.
module pgm_loader_frame_fsm
  import pgm_loader_pkg::*;
#(
  parameter int         ADDR_BUS_WIDTH  = ADDR_BUS_WIDTH_DEF,
  parameter int         ROM_ADDR_WIDTH  = ROM_ADDR_WIDTH_DEF,
  parameter logic [7:0] MAGIC           = MAGIC_DEF,
  parameter string      CORE_RST_AT_POR = "FALSE"
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [7:0]                in_data,
  input  logic                      accept,
  input  logic                      timeout,
  output logic                      in_ready,
  output logic                      frame_active,
  output logic                      wr_en,
  output logic [ADDR_BUS_WIDTH-1:0] wr_addr,
  output logic [7:0]                wr_data,
  output logic                      core_rst,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam logic POR_CORE_RST = (CORE_RST_AT_POR == "TRUE");

  logic [2:0]  state;
  logic [15:0] addr;
  logic [15:0] len;
  logic [15:0] idx;
  logic [7:0]  sum;
  logic [15:0] byte_addr;

  assign in_ready     = (state != S_REPORT);
  assign frame_active = (state != S_IDLE) && (state != S_REPORT);
  assign wr_en        = (state == S_DATA) && accept && !timeout;
  assign wr_data      = in_data;
  assign byte_addr    = addr + idx;

  // NOTE: every output of an always_comb gets a default first, so a partial
  // assignment can never turn into a latch.
  always_comb begin
    wr_addr = '0;
    wr_addr[ROM_ADDR_WIDTH-1:0] = byte_addr[ROM_ADDR_WIDTH-1:0];
  end

  // NOTE: state registers use non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      addr     <= '0;
      len      <= '0;
      idx      <= '0;
      sum      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      core_rst <= POR_CORE_RST;
    end else begin
      done <= 1'b0;
      if (timeout) begin
        // Abandon the frame; core stays in reset since the ROM is partial.
        state <= S_IDLE;
        busy  <= 1'b0;
        err   <= 1'b1;
      end else begin
        case (state)
          S_IDLE: if (accept && in_data == MAGIC) begin
            state    <= S_ADDR_L;
            err      <= 1'b0;
            busy     <= 1'b1;
            core_rst <= 1'b1;
            sum      <= '0;
            idx      <= '0;
          end
          S_ADDR_L: if (accept) begin
            addr[7:0] <= in_data;
            state     <= S_ADDR_H;
          end
          S_ADDR_H: if (accept) begin
            addr[15:8] <= in_data;
            state      <= S_LEN_L;
          end
          S_LEN_L: if (accept) begin
            len[7:0] <= in_data;
            state    <= S_LEN_H;
          end
          S_LEN_H: if (accept) begin
            len[15:8] <= in_data;
            idx       <= '0;
            state     <= ({in_data, len[7:0]} == 16'd0) ? S_CSUM : S_DATA;
          end
          S_DATA: if (accept) begin
            sum <= csum_add(sum, in_data);
            idx <= idx + 16'd1;
            if (idx == len - 16'd1) state <= S_CSUM;
          end
          S_CSUM: if (accept) begin
            state <= S_REPORT;
            if (in_data == sum) begin
              done     <= 1'b1;
              core_rst <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
          S_REPORT: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/pgm_loader.sv
// Program loader top: frame parser, inter-byte timeout and the registered
// ROM write port (strobe, address and data one cycle after the byte).
module pgm_loader
  import pgm_loader_pkg::*;
#(
  parameter int         ADDR_BUS_WIDTH    = ADDR_BUS_WIDTH_DEF,
  parameter int         ROM_ADDR_WIDTH    = ROM_ADDR_WIDTH_DEF,
  parameter logic [7:0] MAGIC             = MAGIC_DEF,
  parameter int         TIMEOUT_CYCLES    = 1000000,
  parameter int         TIMEOUT_CNT_WIDTH = 20,
  parameter string      CORE_RST_AT_POR   = "FALSE"
) (
  input  logic         clk_i,
  input  logic         rst_i,
  pgm_loader_if.slave  bus
);

  logic                         accept;
  logic                         in_ready;
  logic                         frame_active;
  logic                         timeout;
  logic                         wr_en;
  logic [ADDR_BUS_WIDTH-1:0]    wr_addr;
  logic [7:0]                   wr_data;
  logic [TIMEOUT_CNT_WIDTH-1:0] gap_cnt;

  assign accept         = bus.in_valid_i && in_ready;
  assign bus.in_ready_o = in_ready;
  assign timeout        = frame_active && (gap_cnt == TIMEOUT_CNT_WIDTH'(TIMEOUT_CYCLES));

  pgm_loader_frame_fsm #(
    .ADDR_BUS_WIDTH  (ADDR_BUS_WIDTH),
    .ROM_ADDR_WIDTH  (ROM_ADDR_WIDTH),
    .MAGIC           (MAGIC),
    .CORE_RST_AT_POR (CORE_RST_AT_POR)
  ) u_fsm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .in_data      (bus.in_data_i),
    .accept       (accept),
    .timeout      (timeout),
    .in_ready     (in_ready),
    .frame_active (frame_active),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .core_rst     (bus.core_rst_o),
    .busy         (bus.busy_o),
    .done         (bus.done_o),
    .err          (bus.err_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i || !frame_active || accept) begin
      gap_cnt <= '0;
    end else if (!timeout) begin
      gap_cnt <= gap_cnt + TIMEOUT_CNT_WIDTH'(1);
    end
  end

  // Address and data hold between strobes; reset wins over a same-cycle byte.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.pgm_write_o      <= 1'b0;
      bus.pgm_addr_write_o <= '0;
      bus.pgm_data_write_o <= '0;
    end else begin
      bus.pgm_write_o <= wr_en;
      if (wr_en) begin
        bus.pgm_addr_write_o <= wr_addr;
        bus.pgm_data_write_o <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_pgm_loader.sv
// Directed bench for pgm_loader: frames with hand-computed checksums and
// expected ROM writes, compared against a recorded write log.
module tb_pgm_loader;
  import pgm_loader_pkg::*;

  localparam int TMO = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;

  logic [15:0] wa[$];
  logic [7:0]  wd[$];
  logic [15:0] ea[$];
  logic [7:0]  ed[$];

  always #5 clk = ~clk;

  pgm_loader_if #(.ADDR_BUS_WIDTH(16)) bus ();

  pgm_loader #(
    .ADDR_BUS_WIDTH    (16),
    .ROM_ADDR_WIDTH    (15),
    .MAGIC             (8'hA5),
    .TIMEOUT_CYCLES    (TMO),
    .TIMEOUT_CNT_WIDTH (8),
    .CORE_RST_AT_POR   ("FALSE")
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always @(negedge clk) begin
    if (bus.pgm_write_o === 1'b1) begin
      wa.push_back(bus.pgm_addr_write_o);
      wd.push_back(bus.pgm_data_write_o);
    end
    if (bus.done_o === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    @(negedge clk);
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = b;
    while (bus.in_ready_o !== 1'b1 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (bus.in_ready_o !== 1'b1) check("ready_wait", {31'd0, bus.in_ready_o}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    bus.in_data_i  = 8'h00;
  endtask

  // Bytes are taken from the most significant end of v.
  task automatic send_frame(input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++) send_byte(v[8*(n-1-i) +: 8]);
  endtask

  task automatic exp_wr(input logic [15:0] a, input logic [7:0] d);
    ea.push_back(a);
    ed.push_back(d);
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_count"}, wa.size(), ea.size());
    for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), {16'd0, wa[i]}, {16'd0, ea[i]});
      check($sformatf("%s_data%0d", tag, i), {24'd0, wd[i]}, {24'd0, ed[i]});
    end
    wa.delete(); wd.delete(); ea.delete(); ed.delete();
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d0;
    int waited;
    bus.in_valid_i = 1'b0;
    bus.in_data_i  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_ready", bus.in_ready_o, 1);
    check("rst_busy",  bus.busy_o, 0);
    check("rst_err",   bus.err_o, 0);
    check("rst_core",  bus.core_rst_o, 0);
    check("rst_write", bus.pgm_write_o, 0);
    check("rst_done",  bus.done_o, 0);
    check("rst_addr",  bus.pgm_addr_write_o, 0);
    check("rst_data",  bus.pgm_data_write_o, 0);

    // Basic good frame
    d0 = done_cnt;
    send_byte(8'hA5);
    check("a_core_hold", bus.core_rst_o, 1);
    check("a_busy", bus.busy_o, 1);
    send_frame({8'h00, 8'h00, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h66}, 8);
    check("a_done", bus.done_o, 1);
    check("a_core_rel", bus.core_rst_o, 0);
    check("a_report_ready", bus.in_ready_o, 0);
    check("a_err", bus.err_o, 0);
    idle_cycle();
    check("a_busy_end", bus.busy_o, 0);
    check("a_done_end", bus.done_o, 0);
    check("a_done_cnt", done_cnt - d0, 1);
    exp_wr(16'h0000, 8'h11); exp_wr(16'h0001, 8'h22); exp_wr(16'h0002, 8'h33);
    check_writes("a_wr");

    // Bad checksum, then a back-to-back good frame
    d0 = done_cnt;
    send_frame({8'hA5, 8'h00, 8'h00, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h67}, 9);
    check("b_err", bus.err_o, 1);
    check("b_core", bus.core_rst_o, 1);
    check("b_done", bus.done_o, 0);
    exp_wr(16'h0000, 8'h11); exp_wr(16'h0001, 8'h22); exp_wr(16'h0002, 8'h33);
    check_writes("b_wr");
    send_byte(8'hA5);
    check("b2_err_clr", bus.err_o, 0);
    send_frame({8'h00, 8'h00, 8'h01, 8'h00, 8'h42, 8'h42}, 6);
    check("b2_core_rel", bus.core_rst_o, 0);
    idle_cycle();
    check("b_done_cnt", done_cnt - d0, 1);
    exp_wr(16'h0000, 8'h42);
    check_writes("b2_wr");

    // Leading garbage ignored
    d0 = done_cnt;
    send_frame({8'h00, 8'hFF, 8'h5A}, 3);
    check("c_busy_garbage", bus.busy_o, 0);
    check("c_err_garbage", bus.err_o, 0);
    send_frame({8'hA5, 8'h10, 8'h00, 8'h02, 8'h00, 8'hAB, 8'hCD, 8'h78}, 8);
    check("c_err", bus.err_o, 0);
    idle_cycle();
    check("c_done_cnt", done_cnt - d0, 1);
    exp_wr(16'h0010, 8'hAB); exp_wr(16'h0011, 8'hCD);
    check_writes("c_wr");

    // ROM address wrap, and upper address bit dropped
    send_frame({8'hA5, 8'hFE, 8'h7F, 8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A}, 10);
    check("d_err", bus.err_o, 0);
    idle_cycle();
    exp_wr(16'h7FFE, 8'h01); exp_wr(16'h7FFF, 8'h02);
    exp_wr(16'h0000, 8'h03); exp_wr(16'h0001, 8'h04);
    check_writes("d_wr");
    send_frame({8'hA5, 8'h05, 8'h80, 8'h01, 8'h00, 8'h5A, 8'h5A}, 7);
    idle_cycle();
    exp_wr(16'h0005, 8'h5A);
    check_writes("d2_wr");

    // Timeout after two payload bytes
    send_frame({8'hA5, 8'h00, 8'h01, 8'h05, 8'h00, 8'h01, 8'h02}, 7);
    repeat (20) @(negedge clk);
    check("e_err_early", bus.err_o, 0);
    waited = 0;
    while (bus.err_o !== 1'b1 && waited < 4 * TMO) begin
      @(negedge clk);
      waited++;
    end
    check("e_tmo_err", bus.err_o, 1);
    check("e_tmo_busy", bus.busy_o, 0);
    check("e_tmo_core", bus.core_rst_o, 1);
    repeat (10) @(negedge clk);
    exp_wr(16'h0100, 8'h01); exp_wr(16'h0101, 8'h02);
    check_writes("e_wr");
    d0 = done_cnt;
    send_frame({8'hA5, 8'h00, 8'h00, 8'h01, 8'h00, 8'h7E, 8'h7E}, 7);
    check("e2_err", bus.err_o, 0);
    check("e2_core", bus.core_rst_o, 0);
    idle_cycle();
    check("e2_done_cnt", done_cnt - d0, 1);
    exp_wr(16'h0000, 8'h7E);
    check_writes("e2_wr");

    // Zero-length frame
    d0 = done_cnt;
    send_frame({8'hA5, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00}, 6);
    check("f_done", bus.done_o, 1);
    check("f_err", bus.err_o, 0);
    idle_cycle();
    idle_cycle();
    check("f_done_cnt", done_cnt - d0, 1);
    check_writes("f_wr");

    // Reset in the middle of DATA, with a byte accepted on the reset edge
    send_frame({8'hA5, 8'h00, 8'h02, 8'h04, 8'h00, 8'h01}, 6);
    @(negedge clk);
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = 8'h02;
    rst = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    rst = 1'b0;
    check("g_write", bus.pgm_write_o, 0);
    check("g_busy", bus.busy_o, 0);
    check("g_core", bus.core_rst_o, 0);
    check("g_ready", bus.in_ready_o, 1);
    check("g_state", {29'd0, dut.u_fsm.state}, {29'd0, S_IDLE});
    check("g_addr", bus.pgm_addr_write_o, 0);
    exp_wr(16'h0200, 8'h01);
    check_writes("g_wr");
    send_byte(8'h03);
    idle_cycle();
    check("g_busy_after", bus.busy_o, 0);
    check_writes("g2_wr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
